duty_ramp: RTL and testbench
============================

DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 Parameter STEP, default 8'd1, duty increment or decrement applied per ramp step (1..255).
REQ-002 Parameter PERIODS_PER_STEP, default 4, number of PWM periods between ramp steps (1..256).
REQ-003 Parameter DUTY_MAX, default 8'd240, target clamp ceiling; used only with DUTY_RAMP_LIMIT_EN.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tgt_valid  input  1  new target duty offered.
REQ-007 tgt_duty  input  8  requested duty (0-255), sampled on handshake.
REQ-008 tgt_ready  output  1  block can accept a target.
REQ-009 hold  input  1  freeze ramp progress while high.
REQ-010 duty_cycle  output  8  registered duty to the downstream pwm_generator duty_cycle input.
REQ-011 ramp_busy  output  1  ramp in progress.
REQ-012 period_tick  output  1  single-cycle pulse on the last clock of each 256-clock PWM period.

Function
REQ-013 Free-running 8-bit period counter pc shall increment every clk and wrap 255->0; period_tick = (pc == 8'hFF), combinational.
REQ-014 States: IDLE, RAMP_UP, RAMP_DOWN; tgt_ready = (state == IDLE); ramp_busy = (state != IDLE).
REQ-015 Handshake: tgt_valid && tgt_ready in a cycle shall latch tgt_duty (after optional clamp) as target and clear the step divider.
REQ-016 On acceptance: target > duty_cycle -> RAMP_UP; target < duty_cycle -> RAMP_DOWN; target == duty_cycle -> stay IDLE.
REQ-017 tgt_valid while not ready shall be ignored; target shall not change mid-ramp.
REQ-018 In RAMP_*, each period_tick with hold low shall increment the divider; on the tick where divider == PERIODS_PER_STEP-1, divider clears and duty_cycle steps by STEP toward target.
REQ-019 Step arithmetic in 9 bits; result saturates at target (no overshoot, no wrap past 0 or 255).
REQ-020 duty_cycle changes only on the clock edge ending a period_tick cycle, so downstream sees the new value from pc == 0.
REQ-021 When the step makes duty_cycle == target, state returns to IDLE on the same edge; tgt_ready high the next cycle.
REQ-022 hold high: divider and duty_cycle frozen; pc and period_tick continue; state unchanged.
REQ-023 Handshake and period_tick in the same cycle while IDLE: target accepted, no step taken that cycle.

Reset
REQ-024 rst high shall asynchronously force pc=0, divider=0, target=0, duty_cycle=0, state=IDLE; tgt_ready=1, ramp_busy=0, period_tick=0 while in reset.
REQ-025 rst mid-ramp shall abort the ramp; duty_cycle returns to 0 immediately, no partial step.

Configuration
REQ-026 Macro DUTY_RAMP_LIMIT_EN defined: accepted target = min(tgt_duty, DUTY_MAX).
REQ-027 Macro DUTY_RAMP_LIMIT_EN undefined: target = tgt_duty unmodified; DUTY_MAX unused.

Structure
REQ-028 Package duty_ramp_pkg shall hold the state enum, DUTY_W=8, PC_W=8 constants.
REQ-029 Sub-module period_timebase shall contain pc and period_tick; duty_ramp instantiates it once.

Verification
REQ-030 Reset: rst=1 for 20 ns -> duty_cycle=0, tgt_ready=1, ramp_busy=0; rst release -> first period_tick 256 clocks later.
REQ-031 Ramp up: STEP=1, PERIODS_PER_STEP=4, target 4 from 0 -> duty 1,2,3,4 on every 4th period_tick, IDLE after the 16th tick.
REQ-032 Saturation/down: STEP=8, from 20 target 3 -> duty 12, 4, 3; never below 3; ramp_busy falls with the final step.
REQ-033 Hold: hold=1 for 3 periods mid-ramp -> duty frozen, step schedule shifted by exactly 3 ticks.
REQ-034 Busy/simultaneous: tgt_valid during RAMP_UP ignored; target==duty offered -> stays IDLE; handshake on period_tick -> no step that cycle.
REQ-035 Limit: with DUTY_RAMP_LIMIT_EN, target 255 -> final duty 240; without macro -> final duty 255; rst mid-ramp -> duty 0 at once.

Source files
------------

// File: rtl/duty_ramp_pkg.sv
// Shared types and step arithmetic for the duty_ramp block.
`timescale 1ns/1ps
package duty_ramp_pkg;

  localparam int DUTY_W = 8;
  localparam int PC_W   = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

  // One ramp step toward target; 9-bit math so neither direction can wrap or overshoot.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] duty,
    input logic [DUTY_W-1:0] target,
    input logic [DUTY_W-1:0] step,
    input logic              up
  );
    logic [DUTY_W:0]   acc;
    logic [DUTY_W-1:0] res;
    if (up) begin
      acc = {1'b0, duty} + {1'b0, step};
      res = (acc >= {1'b0, target}) ? target : acc[DUTY_W-1:0];
    end else begin
      acc = {1'b0, duty} - {1'b0, step};
      res = (acc[DUTY_W] || (acc[DUTY_W-1:0] <= target)) ? target : acc[DUTY_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/duty_ramp_period_timebase.sv
// Free-running PWM period counter; period_tick marks the last clock of each period.
// Latency: period_tick is combinational from the registered counter.
// Backpressure: none, the counter never stalls.
`timescale 1ns/1ps
module period_timebase
  import duty_ramp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic period_tick
);

  logic [PC_W-1:0] pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else begin
      pc <= pc + 1'b1;
    end
  end

  assign period_tick = (pc == {PC_W{1'b1}});

endmodule

// File: rtl/duty_ramp.sv
// Ramps a registered PWM duty toward an accepted target by STEP every PERIODS_PER_STEP periods; DUTY_RAMP_LIMIT_EN clamps targets to DUTY_MAX.
// Latency: duty moves only on the edge ending a period_tick cycle; state returns to IDLE with the final step.
// Backpressure: tgt_ready is low for the whole ramp; offers made while busy are dropped, hold freezes progress.
`timescale 1ns/1ps
module duty_ramp
  import duty_ramp_pkg::*;
#(
  parameter logic [DUTY_W-1:0] STEP             = 8'd1,
  parameter int                PERIODS_PER_STEP = 4,
  parameter logic [DUTY_W-1:0] DUTY_MAX         = 8'd240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tgt_valid,
  input  logic [DUTY_W-1:0] tgt_duty,
  output logic              tgt_ready,
  input  logic              hold,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              ramp_busy,
  output logic              period_tick
);

`ifdef DUTY_RAMP_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [7:0] DIV_LAST = 8'(PERIODS_PER_STEP - 1);

  ramp_state_t       state;
  logic [DUTY_W-1:0] target;
  logic [7:0]        div;
  logic [DUTY_W-1:0] tgt_clamped;
  logic [DUTY_W-1:0] duty_next;
  logic              step_now;

  period_timebase u_timebase (
    .clk         (clk),
    .rst         (rst),
    .period_tick (period_tick)
  );

  // With the limit disabled this folds away and the target passes through untouched.
  assign tgt_clamped = (LIMIT_EN && (tgt_duty > DUTY_MAX)) ? DUTY_MAX : tgt_duty;

  always_comb begin
    duty_next = step_toward(duty_cycle, target, STEP, state == RAMP_UP);
  end

  assign step_now  = period_tick && !hold && (div == DIV_LAST);
  assign tgt_ready = (state == IDLE);
  assign ramp_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      target     <= '0;
      duty_cycle <= '0;
      div        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // A tick coinciding with acceptance is not counted toward the first step.
          if (tgt_valid) begin
            target <= tgt_clamped;
            div    <= '0;
            if (tgt_clamped > duty_cycle) begin
              state <= RAMP_UP;
            end else if (tgt_clamped < duty_cycle) begin
              state <= RAMP_DOWN;
            end
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (step_now) begin
            div        <= '0;
            duty_cycle <= duty_next;
            if (duty_next == target) begin
              state <= IDLE;
            end
          end else if (period_tick && !hold) begin
            div <= div + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// Scoreboard bench: stimulus queues expected duty changes, monitors pop them as the outputs move.
`timescale 1ns/1ps
module tb_duty_ramp;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_vld, b_vld, hold_a, hold_b;
  logic [7:0] a_tgt, b_tgt;
  logic       a_rdy, a_busy, a_pt, b_rdy, b_busy, b_pt;
  logic [7:0] a_duty, b_duty;
  logic [7:0] prev_a = 8'd0;
  logic [7:0] prev_b = 8'd0;

  int errors = 0;
  int checks = 0;
  int cyc;

  typedef struct {
    logic [7:0] duty;
    int         at;
    logic       busy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  duty_ramp #(.STEP(8'd1), .PERIODS_PER_STEP(4)) dut_a (
    .clk(clk), .rst(rst), .tgt_valid(a_vld), .tgt_duty(a_tgt), .tgt_ready(a_rdy),
    .hold(hold_a), .duty_cycle(a_duty), .ramp_busy(a_busy), .period_tick(a_pt)
  );

  duty_ramp #(.STEP(8'd8), .PERIODS_PER_STEP(1)) dut_b (
    .clk(clk), .rst(rst), .tgt_valid(b_vld), .tgt_duty(b_tgt), .tgt_ready(b_rdy),
    .hold(hold_b), .duty_cycle(b_duty), .ramp_busy(b_busy), .period_tick(b_pt)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; equals the DUT period counter modulo 256.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_a(input int d, input int at, input logic busy);
    exp_t e;
    e.duty = 8'(d);
    e.at   = at;
    e.busy = busy;
    qa.push_back(e);
  endtask

  task automatic push_b(input int d, input int at, input logic busy);
    exp_t e;
    e.duty = 8'(d);
    e.at   = at;
    e.busy = busy;
    qb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic offer_a(input int c, input logic [7:0] d);
    wait_until(c);
    a_tgt = d;
    a_vld = 1'b1;
    @(negedge clk);
    a_vld = 1'b0;
  endtask

  task automatic offer_b(input int c, input logic [7:0] d);
    wait_until(c);
    b_tgt = d;
    b_vld = 1'b1;
    @(negedge clk);
    b_vld = 1'b0;
  endtask

  // Monitors: every duty change must match the head of its queue in value, cycle and busy.
  always @(negedge clk) begin
    if (a_duty !== prev_a) begin
      if (qa.size() == 0) begin
        check("a_unexpected_change", int'(a_duty), int'(prev_a));
      end else begin
        check("a_duty", int'(a_duty), int'(qa[0].duty));
        if (qa[0].at >= 0) check("a_step_cycle", cyc, qa[0].at);
        check("a_busy_after_step", int'(a_busy), int'(qa[0].busy));
        void'(qa.pop_front());
      end
    end
    prev_a <= a_duty;
  end

  always @(negedge clk) begin
    if (b_duty !== prev_b) begin
      if (qb.size() == 0) begin
        check("b_unexpected_change", int'(b_duty), int'(prev_b));
      end else begin
        check("b_duty", int'(b_duty), int'(qb[0].duty));
        if (qb[0].at >= 0) check("b_step_cycle", cyc, qb[0].at);
        check("b_busy_after_step", int'(b_busy), int'(qb[0].busy));
        void'(qb.pop_front());
      end
    end
    prev_b <= b_duty;
  end

  always @(negedge clk) begin
    if (a_pt || b_pt || ((cyc % 256 == 255) && !rst)) begin
      check("a_period_tick", int'(a_pt), int'((cyc % 256 == 255) && !rst));
      check("b_period_tick", int'(b_pt), int'((cyc % 256 == 255) && !rst));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation stuck at cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lim;
    int d;
    int k;
    rst = 1'b1;
    a_vld = 1'b0; b_vld = 1'b0; hold_a = 1'b0; hold_b = 1'b0;
    a_tgt = 8'd0; b_tgt = 8'd0;
`ifdef DUTY_RAMP_LIMIT_EN
    lim = 240;
`else
    lim = 255;
`endif

    #18;
    check("reset_a_duty", int'(a_duty), 0);
    check("reset_a_ready", int'(a_rdy), 1);
    check("reset_a_busy", int'(a_busy), 0);
    check("reset_a_tick", int'(a_pt), 0);
    check("reset_b_duty", int'(b_duty), 0);
    @(negedge clk);
    rst = 1'b0;

    fork
      begin
        push_a(1, 1024, 1'b1);
        push_a(2, 2048, 1'b1);
        push_a(3, 3072, 1'b1);
        push_a(4, 4096, 1'b0);
        offer_a(10, 8'd4);

        wait_until(1500);
        a_tgt = 8'd100;
        a_vld = 1'b1;
        check("a_ready_mid_ramp", int'(a_rdy), 0);
        check("a_busy_mid_ramp", int'(a_busy), 1);
        repeat (3) @(negedge clk);
        a_vld = 1'b0;

        offer_a(4200, 8'd4);
        check("a_equal_target_idle", int'(a_busy), 0);
        check("a_equal_target_ready", int'(a_rdy), 1);

        push_a(5, 5376, 1'b1);
        push_a(6, 7168, 1'b0);
        offer_a(4351, 8'd6);
        check("a_no_step_on_handshake_tick", int'(a_duty), 4);
        check("a_busy_after_tick_handshake", int'(a_busy), 1);

        wait_until(5400);
        hold_a = 1'b1;
        wait_until(6200);
        check("a_duty_frozen_in_hold", int'(a_duty), 5);
        check("a_busy_in_hold", int'(a_busy), 1);
        hold_a = 1'b0;

        wait_until(7200);
        check("a_final_after_hold", int'(a_duty), 6);
        check("a_ready_after_hold", int'(a_rdy), 1);
      end
      begin
        push_b(8, 256, 1'b1);
        push_b(16, 512, 1'b1);
        push_b(20, 768, 1'b0);
        offer_b(10, 8'd20);

        push_b(12, 1024, 1'b1);
        push_b(4, 1280, 1'b1);
        push_b(3, 1536, 1'b0);
        offer_b(800, 8'd3);
        wait_until(1500);
        check("b_busy_before_final_down", int'(b_busy), 1);

        d = 3;
        k = 1;
        while (d != lim) begin
          d = (d + 8 >= lim) ? lim : d + 8;
          push_b(d, 1536 + 256 * k, d != lim);
          k++;
        end
        offer_b(1600, 8'd255);
        wait_until(9750);
        check("b_final_duty_limit", int'(b_duty), lim);
        check("b_ready_after_limit", int'(b_rdy), 1);

        push_b(lim - 8, 9984, 1'b1);
        offer_b(9800, 8'd0);
      end
    join

    wait_until(10100);
    push_a(0, -1, 1'b0);
    push_b(0, -1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_ramp_b_duty", int'(b_duty), 0);
    check("rst_mid_ramp_b_busy", int'(b_busy), 0);
    check("rst_mid_ramp_b_ready", int'(b_rdy), 1);
    check("rst_a_duty", int'(a_duty), 0);
    check("rst_tick_low", int'(b_pt), 0);
    #17;
    @(negedge clk);
    rst = 1'b0;
    wait_until(300);

    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
